quantizer_lanes: RTL and testbench

Multi-lane INT32-to-INT8 requantizer with per-output-channel parameters, used in the post-accumulator path of the conv engine. Each beat carries LANES consecutive output channels. Each lane applies: optional leaky ReLU, multiply by M, arithmetic shift by n, clamp. Per-channel M/n/relu sit in an internal table loaded over a config port. Streams use valid/ready with backpressure and frame drain.

---
 rtl/quant_pkg.sv | 21 ++
 rtl/quant_lane.sv | 81 ++++++++
 rtl/quantizer_lanes.sv | 126 ++++++++++++
 tb/tb_quantizer_lanes.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quant_pkg.sv
// Shared types and constants for the INT32->INT8 requantizer lanes.
// Build option QUANT_ROUND_EN (see quant_lane) does not change anything here.
package quant_pkg;

  localparam int QM_W       = 32;
  localparam int QN_W       = 5;
  localparam int PIPE_DEPTH = 5;

  typedef struct packed {
    logic [QM_W-1:0] m;
    logic [QN_W-1:0] n;
    logic            relu;
  } quant_param_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } quant_state_t;

endpackage

// File: rtl/quant_lane.sv
// One requantizer lane, stages S1..S4: leaky ReLU, multiply, shift, clamp.
// Define QUANT_ROUND_EN to round half up in the shift stage; default is floor.
module quant_lane
  import quant_pkg::*;
#(
  parameter int IN_W        = 32,
  parameter int OUT_W       = 8,
  parameter int M_W         = QM_W,
  parameter int N_W         = QN_W,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  x,
  input  logic [M_W-1:0]   m,
  input  logic [N_W-1:0]   n,
  input  logic             relu,
  output logic [OUT_W-1:0] y
);

  localparam int PW = IN_W + M_W + 1;
  localparam logic signed [PW-1:0] MAXV = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] x_s;
  logic signed [IN_W-1:0] leaky;
  logic signed [IN_W-1:0] x1;
  logic [M_W-1:0]         m1;
  logic [N_W-1:0]         n1;
  logic [N_W-1:0]         n2;
  logic signed [PW-1:0]   xe;
  logic signed [PW-1:0]   me;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   p2;
  logic signed [PW-1:0]   sh;
  logic signed [PW-1:0]   q3;
  logic [OUT_W-1:0]       sat;
`ifdef QUANT_ROUND_EN
  logic signed [PW-1:0]   rnd;
`endif

  always_comb begin
    x_s   = signed'(x);
    leaky = (relu && x_s < 0) ? (x_s >>> LEAKY_SHIFT) : x_s;
    // M is unsigned: zero-extend it so the product keeps the sign of x only.
    xe    = {{(PW-IN_W){x1[IN_W-1]}}, x1};
    me    = {{(PW-M_W){1'b0}}, m1};
    prod  = xe * me;
`ifdef QUANT_ROUND_EN
    rnd   = (n2 != '0) ? signed'(PW'(1) << (n2 - N_W'(1))) : '0;
    sh    = (p2 + rnd) >>> n2;
`else
    sh    = p2 >>> n2;
`endif
    if (q3 > MAXV)      sat = MAXV[OUT_W-1:0];
    else if (q3 < MINV) sat = MINV[OUT_W-1:0];
    else                sat = q3[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x1 <= '0;
      m1 <= '0;
      n1 <= '0;
      p2 <= '0;
      n2 <= '0;
      q3 <= '0;
      y  <= '0;
    end else if (en) begin
      x1 <= leaky;
      m1 <= m;
      n1 <= n;
      p2 <= prod;
      n2 <= n1;
      q3 <= sh;
      y  <= sat;
    end
  end

endmodule

// File: rtl/quantizer_lanes.sv
// Multi-lane requantizer top: per-channel parameter table, group counter, FSM, valid/last pipe.
// Optional rounding is selected by QUANT_ROUND_EN inside quant_lane.
module quantizer_lanes
  import quant_pkg::*;
#(
  parameter int LANES       = 8,
  parameter int IN_W        = 32,
  parameter int OUT_W       = 8,
  parameter int M_W         = QM_W,
  parameter int N_W         = QN_W,
  parameter int NUM_CH      = 256,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_we,
  input  logic [$clog2(NUM_CH)-1:0]            cfg_ch,
  input  logic [M_W-1:0]                       cfg_m,
  input  logic [N_W-1:0]                       cfg_n,
  input  logic                                 cfg_relu,
  output logic                                 cfg_ready,
  input  logic [$clog2(NUM_CH/LANES):0]        cfg_groups,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [LANES*IN_W-1:0]                s_data,
  input  logic                                 s_last,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [LANES*OUT_W-1:0]               m_data,
  output logic                                 m_last,
  output logic [1:0]                           fsm_state
);

  localparam int GROUPS = NUM_CH / LANES;
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int L_W    = $clog2(LANES);
  localparam int G_W    = $clog2(GROUPS);
  localparam int VW     = PIPE_DEPTH - 1;

  // Handshake: a beat moves when valid && ready are both high on a rising edge;
  // the whole pipe advances only when the output register is empty or being taken.
  quant_state_t state, state_nx;
  quant_param_t tbl [GROUPS][LANES];
  quant_param_t p0 [LANES];
  logic [LANES*IN_W-1:0] d0;
  logic [G_W-1:0]        grp;
  logic [VW-1:0]         vld;
  logic [VW-1:0]         lst;
  logic                  adv;
  logic                  s_fire;

  assign adv       = !m_valid || m_ready;
  assign s_ready   = adv && (state != DRAIN);
  assign s_fire    = s_valid && s_ready;
  assign cfg_ready = (state == IDLE);
  assign fsm_state = state;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (s_fire) state_nx = s_last ? DRAIN : STREAM;
      STREAM:  if (s_fire && s_last) state_nx = DRAIN;
      // Leave DRAIN on the edge where the final output beat is taken.
      DRAIN:   if (vld == '0 && adv) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Table is never reset; a same-cycle read sees the old entry (read-before-write).
  always_ff @(posedge clk) begin
    if (cfg_we && cfg_ready)
      tbl[cfg_ch[CH_W-1:L_W]][cfg_ch[L_W-1:0]] <= '{m: cfg_m, n: cfg_n, relu: cfg_relu};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grp <= '0;
    end else if (s_fire) begin
      if (s_last || ({1'b0, grp} == cfg_groups - (G_W+1)'(1))) grp <= '0;
      else                                                     grp <= grp + G_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld     <= '0;
      lst     <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      d0      <= '0;
      for (int l = 0; l < LANES; l++) p0[l] <= '0;
    end else if (adv) begin
      vld     <= {vld[VW-2:0], s_fire};
      lst     <= {lst[VW-2:0], s_fire && s_last};
      m_valid <= vld[VW-1];
      m_last  <= lst[VW-1];
      d0      <= s_data;
      for (int l = 0; l < LANES; l++) p0[l] <= tbl[grp][l];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    quant_lane #(
      .IN_W       (IN_W),
      .OUT_W      (OUT_W),
      .M_W        (QM_W),
      .N_W        (QN_W),
      .LEAKY_SHIFT(LEAKY_SHIFT)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (adv),
      .x   (d0[l*IN_W +: IN_W]),
      .m   (p0[l].m),
      .n   (p0[l].n),
      .relu(p0[l].relu),
      .y   (m_data[l*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_quantizer_lanes.sv
// Directed bench for quantizer_lanes; expected values follow QUANT_ROUND_EN when defined.
module tb_quantizer_lanes;
  import quant_pkg::*;

  localparam int LANES  = 8;
  localparam int IN_W   = 32;
  localparam int OUT_W  = 8;
  localparam int NUM_CH = 256;
  localparam int DW     = LANES * OUT_W;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cfg_we;
  logic [7:0]             cfg_ch;
  logic [31:0]            cfg_m;
  logic [4:0]             cfg_n;
  logic                   cfg_relu;
  logic                   cfg_ready;
  logic [5:0]             cfg_groups;
  logic                   s_valid;
  logic                   s_ready;
  logic [LANES*IN_W-1:0]  s_data;
  logic                   s_last;
  logic                   m_valid;
  logic                   m_ready;
  logic [DW-1:0]          m_data;
  logic                   m_last;
  logic [1:0]             fsm_state;

  always #5 clk = ~clk;

  quantizer_lanes dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_m     (cfg_m),
    .cfg_n     (cfg_n),
    .cfg_relu  (cfg_relu),
    .cfg_ready (cfg_ready),
    .cfg_groups(cfg_groups),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .fsm_state (fsm_state)
  );

  int            n_assert = 0;
  int            n_fail   = 0;
  int            out_no   = 0;
  logic [DW:0]   exp_q[$];
  logic [31:0]   mdl_m    [NUM_CH];
  logic [4:0]    mdl_n    [NUM_CH];
  logic          mdl_relu [NUM_CH];
  bit            rand_ready = 0;
  int            hold_cnt   = 0;
  logic          stall_prev = 1'b0;
  logic [DW:0]   prev_out   = '0;
  logic          s_fire     = 1'b0;

  task automatic check(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: choose m_ready, sample handshakes mid-cycle, then step past the edge.
  task automatic cycle();
    logic [DW:0] got;
    if (hold_cnt > 0) begin
      m_ready = 1'b0;
      hold_cnt--;
    end else if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
    else                     m_ready = 1'b1;
    #1;
    s_fire = s_valid && s_ready;
    got    = {m_last, m_data};
    if (stall_prev) begin
      check("hold_valid", DW'(m_valid), DW'(1));
      check("hold_data", got, prev_out);
    end
    if (m_valid && !m_ready) check("s_ready_stall", DW'(s_ready), DW'(0));
    if (m_valid && m_ready) begin
      check("beat_expected", DW'(exp_q.size() != 0), DW'(1));
      if (exp_q.size() != 0) check($sformatf("beat%0d", out_no), got, exp_q.pop_front());
      out_no++;
    end
    stall_prev = m_valid && !m_ready;
    prev_out   = got;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input logic [31:0] m, input logic [4:0] n, input logic relu);
    cfg_we   = 1'b1;
    cfg_ch   = 8'(ch);
    cfg_m    = m;
    cfg_n    = n;
    cfg_relu = relu;
    cycle();
    cfg_we       = 1'b0;
    mdl_m[ch]    = m;
    mdl_n[ch]    = n;
    mdl_relu[ch] = relu;
  endtask

  task automatic send_beat(input logic [LANES*IN_W-1:0] d, input logic last, input logic [DW:0] exp);
    int guard = 0;
    exp_q.push_back(exp);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    s_fire  = 1'b0;
    while (!s_fire && guard < 200) begin
      cycle();
      guard++;
    end
    check("accept", DW'(s_fire), DW'(1));
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      check("cfg_ready_busy", DW'(cfg_ready), DW'(0));
      cycle();
      guard++;
    end
    check("drain_done", DW'(exp_q.size()), DW'(0));
    check("cfg_ready_idle", DW'(cfg_ready), DW'(1));
    check("state_idle", DW'(fsm_state), DW'(IDLE));
  endtask

  function automatic logic [DW:0] mk(input logic last, input logic [7:0] b);
    return {last, {LANES{b}}};
  endfunction

  function automatic logic [LANES*IN_W-1:0] rep(input int x);
    logic [31:0] w;
    w = x;
    return {LANES{w}};
  endfunction

  function automatic logic [DW:0] grp_exp(input logic last, input int g);
    logic [DW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*8 +: 8] = 8'(8*g + l + 1);
    return {last, r};
  endfunction

  function automatic logic [7:0] ref_lane(input logic signed [31:0] x, input int ch);
    logic signed [95:0] v;
    v = 96'(x);
    if (mdl_relu[ch] && x < 0) v = -((-v + 96'sd7) / 96'sd8);
    v = v * $signed({1'b0, mdl_m[ch]});
`ifdef QUANT_ROUND_EN
    if (mdl_n[ch] != 0) v = v + (96'sd1 <<< (mdl_n[ch] - 1));
`endif
    v = v >>> mdl_n[ch];
    if (v > 127)  return 8'h7f;
    if (v < -128) return 8'h80;
    return v[7:0];
  endfunction

  function automatic logic [DW:0] model_beat(input logic [LANES*IN_W-1:0] d, input int g, input logic last);
    logic [DW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*8 +: 8] = ref_lane(signed'(d[l*IN_W +: IN_W]), g*LANES + l);
    return {last, r};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW:0]           e;
    logic [LANES*IN_W-1:0] d;
    int                    lat;

    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_m = '0; cfg_n = '0; cfg_relu = 1'b0;
    cfg_groups = 6'd1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_m_valid", DW'(m_valid), DW'(0));
    check("rst_m_data", DW'(m_data), DW'(0));
    check("rst_m_last", DW'(m_last), DW'(0));
    check("rst_cfg_ready", DW'(cfg_ready), DW'(1));
    check("rst_s_ready", DW'(s_ready), DW'(1));
    check("rst_state", DW'(fsm_state), DW'(IDLE));

    for (int c = 0; c < NUM_CH; c++) cfg_write(c, 32'd1, 5'd0, 1'b0);

    // Leaky ReLU on, then off; first beat also measures accept-to-valid latency.
    for (int c = 0; c < LANES; c++) cfg_write(c, 32'd1, 5'd0, 1'b1);
    send_beat(rep(-80), 1'b1, mk(1'b1, 8'hF6));
    lat = 1;
    while (!m_valid && lat < 20) begin
      cycle();
      lat++;
    end
    check("latency", DW'(lat), DW'(5));
    wait_idle();
    for (int c = 0; c < LANES; c++) cfg_write(c, 32'd1, 5'd0, 1'b0);
    send_beat(rep(-80), 1'b1, mk(1'b1, 8'hB0));
    wait_idle();

    // Clamp boundaries with M=1, n=0.
    send_beat(rep(127),  1'b0, mk(1'b0, 8'h7F));
    send_beat(rep(128),  1'b0, mk(1'b0, 8'h7F));
    send_beat(rep(-128), 1'b0, mk(1'b0, 8'h80));
    send_beat(rep(-129), 1'b0, mk(1'b0, 8'h80));
    send_beat(rep(1000), 1'b1, mk(1'b1, 8'h7F));
    wait_idle();

    // Scale by 2^30 / 2^31.
    for (int c = 0; c < LANES; c++) cfg_write(c, 32'h4000_0000, 5'd31, 1'b0);
    send_beat(rep(200), 1'b0, mk(1'b0, 8'h64));
    send_beat(rep(300), 1'b0, mk(1'b0, 8'h7F));
`ifdef QUANT_ROUND_EN
    send_beat(rep(-7), 1'b0, mk(1'b0, 8'hFD));
`else
    send_beat(rep(-7), 1'b0, mk(1'b0, 8'hFC));
`endif
    send_beat(rep(32'h7FFF_FFFF), 1'b0, mk(1'b0, 8'h7F));
    send_beat(rep(32'h8000_0000), 1'b1, mk(1'b1, 8'h80));
    wait_idle();

    // Rounding: 3/2 and -3/2.
    for (int c = 0; c < LANES; c++) cfg_write(c, 32'd1, 5'd1, 1'b0);
`ifdef QUANT_ROUND_EN
    send_beat(rep(3),  1'b0, mk(1'b0, 8'h02));
    send_beat(rep(-3), 1'b1, mk(1'b1, 8'hFF));
`else
    send_beat(rep(3),  1'b0, mk(1'b0, 8'h01));
    send_beat(rep(-3), 1'b1, mk(1'b1, 8'hFE));
`endif
    wait_idle();

    // Group walk: channel c has M=c+1.
    for (int c = 0; c < 3*LANES; c++) cfg_write(c, 32'(c + 1), 5'd0, 1'b0);
    cfg_groups = 6'd2;
    send_beat(rep(1), 1'b0, grp_exp(1'b0, 0));
    send_beat(rep(1), 1'b0, grp_exp(1'b0, 1));
    send_beat(rep(1), 1'b0, grp_exp(1'b0, 0));
    send_beat(rep(1), 1'b1, grp_exp(1'b1, 1));
    wait_idle();
    cfg_groups = 6'd3;
    send_beat(rep(1), 1'b0, grp_exp(1'b0, 0));
    send_beat(rep(1), 1'b1, grp_exp(1'b1, 1));
    wait_idle();
    send_beat(rep(1), 1'b1, grp_exp(1'b1, 0));
    wait_idle();
    send_beat(rep(1), 1'b0, grp_exp(1'b0, 0));
    send_beat(rep(1), 1'b0, grp_exp(1'b0, 1));
    send_beat(rep(1), 1'b1, grp_exp(1'b1, 2));
    wait_idle();

    // Config writes outside IDLE are ignored.
    cfg_groups = 6'd1;
    for (int c = 0; c < LANES; c++) cfg_write(c, 32'd1, 5'd0, 1'b0);
    send_beat(rep(5), 1'b0, mk(1'b0, 8'h05));
    check("state_stream", DW'(fsm_state), DW'(STREAM));
    check("cfg_ready_stream", DW'(cfg_ready), DW'(0));
    cfg_we = 1'b1; cfg_ch = 8'd0; cfg_m = 32'd100; cfg_n = 5'd0; cfg_relu = 1'b0;
    cycle();
    cfg_we = 1'b0;
    send_beat(rep(5), 1'b1, mk(1'b1, 8'h05));
    check("state_drain", DW'(fsm_state), DW'(DRAIN));
    cfg_we = 1'b1; cfg_ch = 8'd1; cfg_m = 32'd50;
    cycle();
    cfg_we = 1'b0;
    wait_idle();
    send_beat(rep(5), 1'b1, mk(1'b1, 8'h05));
    wait_idle();

    // Write and accept in the same IDLE cycle: beat sees the old entry.
    cfg_we = 1'b1; cfg_ch = 8'd0; cfg_m = 32'd3; cfg_n = 5'd0; cfg_relu = 1'b0;
    send_beat(rep(5), 1'b1, mk(1'b1, 8'h05));
    cfg_we   = 1'b0;
    mdl_m[0] = 32'd3;
    wait_idle();
    e = mk(1'b1, 8'h05);
    e[7:0] = 8'h0F;
    send_beat(rep(5), 1'b1, e);
    wait_idle();

    // Random backpressure against the model, with a 10-cycle hold mid-frame.
    cfg_groups = 6'd2;
    for (int c = 0; c < 2*LANES; c++)
      cfg_write(c, 32'($urandom_range(1, 1000)), 5'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
    rand_ready = 1;
    for (int b = 0; b < 24; b++) begin
      for (int l = 0; l < LANES; l++) d[l*IN_W +: IN_W] = 32'($urandom_range(0, 200000)) - 32'd100000;
      if (b == 8) hold_cnt = 10;
      send_beat(d, b == 23, model_beat(d, b % 2, b == 23));
    end
    wait_idle();
    rand_ready = 0;

    // Reset in the middle of a frame.
    for (int b = 0; b < 7; b++) send_beat(rep(b + 1), 1'b0, model_beat(rep(b + 1), b % 2, 1'b0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_m_valid", DW'(m_valid), DW'(0));
    check("midrst_state", DW'(fsm_state), DW'(IDLE));
    check("midrst_cfg_ready", DW'(cfg_ready), DW'(1));
    exp_q.delete();
    stall_prev = 1'b0;
    d = rep(-1000);
    d[IN_W +: IN_W] = 32'd777;
    send_beat(d, 1'b1, model_beat(d, 0, 1'b1));
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
